// File: rtl/fixed_pt_mantissa_mult_unit.sv
// Shared iterative radix-2^STEP shift-add multiplier for hidden-bit mantissas.
// Valid/ready request in, valid/ready full-width product out.
module fixed_pt_mantissa_mult_unit #(
   parameter int unsigned WIDTH = 11,
   parameter int unsigned STEP  = 2
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [WIDTH-1:0]     inp_a,
   input  logic [WIDTH-1:0]     inp_b,
   input  logic                 in_valid,
   output logic                 in_ready,
   output logic [2*WIDTH-1:0]   out,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic                 busy
);

   localparam int unsigned ITER = (WIDTH + STEP - 1) / STEP;
   localparam int unsigned BW   = ITER * STEP;
   localparam int unsigned PW   = WIDTH + STEP;
   localparam int unsigned CW   = (ITER > 1) ? $clog2(ITER) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(ITER - 1);

   typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

   state_t               state_q, state_d;
   logic [WIDTH-1:0]     a_q, a_d;
   logic [BW-1:0]        b_q, b_d;
   logic [2*WIDTH-1:0]   acc_q, acc_d;
   logic [CW-1:0]        cnt_q, cnt_d;

   logic [PW-1:0]        pp;
   logic [2*WIDTH-1:0]   pp_ext;
   logic                 accept;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         a_q     <= '0;
         b_q     <= '0;
         acc_q   <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         acc_q   <= acc_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      a_d      = a_q;
      b_d      = b_q;
      acc_d    = acc_q;
      cnt_d    = cnt_q;
      // Partial product is WIDTH+STEP wide; widened before the positional shift.
      pp       = {{STEP{1'b0}}, a_q} * PW'(b_q[STEP-1:0]);
      pp_ext   = '0;
      pp_ext[PW-1:0] = pp;
      in_ready = ~rst & ((state_q == IDLE) | ((state_q == DONE) & out_ready));
      accept   = in_valid & in_ready;

      case (state_q)
         CALC: begin
            acc_d = acc_q + (pp_ext << (cnt_q * STEP));
            b_d   = b_q >> STEP;
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == CNT_LAST) begin
               state_d = DONE;
            end
         end
         DONE: begin
            if (out_ready) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      // A request taken in IDLE or chained from DONE overrides the above.
      if (accept) begin
         state_d = CALC;
         a_d     = inp_a;
         b_d     = '0;
         b_d[WIDTH-1:0] = inp_b;
         acc_d   = '0;
         cnt_d   = '0;
      end
   end

   assign out       = acc_q;
   assign out_valid = (state_q == DONE);
   assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_fixed_pt_mantissa_mult_unit.sv
// Scoreboard bench: driver pushes reference products on accept, monitor pops
// and compares on every output handshake, also checking latency and hold.
module tb_fixed_pt_mantissa_mult_unit;

   localparam int unsigned W       = 11;
   localparam int unsigned TB_STEP = 2;
   localparam int unsigned ITER    = (W + TB_STEP - 1) / TB_STEP;

   logic            clk = 1'b0;
   logic            rst;
   logic [W-1:0]    inp_a, inp_b;
   logic            in_valid;
   logic            in_ready;
   logic [2*W-1:0]  out;
   logic            out_valid;
   logic            out_ready;
   logic            busy;

   typedef struct {
      longint unsigned exp;
      int              acc_cyc;
   } item_t;

   item_t           sb[$];
   int              vectors = 0;
   int              miscompares = 0;
   int              cyc = 0;
   bit              rand_rdy = 1'b0;
   bit              prev_valid = 1'b0;
   logic [2*W-1:0]  held;

   fixed_pt_mantissa_mult_unit #(.WIDTH(W), .STEP(TB_STEP)) dut (
      .clk       (clk),
      .rst       (rst),
      .inp_a     (inp_a),
      .inp_b     (inp_b),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .out       (out),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .busy      (busy)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic longint unsigned ref_mul(input longint unsigned a, input longint unsigned b);
      return a * b;
   endfunction

   task automatic check(input string name, input longint unsigned act, input longint unsigned exp);
      vectors++;
      if (act != exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic fail_now(input string name);
      vectors++;
      miscompares++;
      $display("FAIL %s (t=%0t)", name, $time);
   endtask

   always @(negedge clk) begin
      if (rst) begin
         prev_valid = 1'b0;
      end else begin
         if (out_valid && !prev_valid) begin
            held = out;
            if (sb.size() == 0) fail_now("unexpected_out_valid");
            else check("latency", longint'(cyc - sb[0].acc_cyc), ITER);
         end else if (out_valid) begin
            check("hold_out", out, held);
         end
         if (out_valid && !out_ready) check("in_ready_backpressure", in_ready, 0);
         if (out_valid && out_ready) begin
            if (sb.size() == 0) fail_now("unexpected_handshake");
            else begin
               item_t it;
               it = sb.pop_front();
               check("product", out, it.exp);
            end
         end
         prev_valid = out_valid;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
      if (rand_rdy) out_ready = ($urandom_range(0, 3) != 0);
   endtask

   task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input bit keep);
      bit ok;
      ok = 1'b0;
      inp_a = a;
      inp_b = b;
      in_valid = 1'b1;
      for (int i = 0; i < 500 && !ok; i++) begin
         @(negedge clk);
         if (in_ready) begin
            sb.push_back('{ref_mul(a, b), cyc + 1});
            ok = 1'b1;
         end
         tick();
      end
      if (!ok) fail_now("accept_timeout");
      if (!keep) in_valid = 1'b0;
   endtask

   task automatic wait_idle(input int max);
      bit done;
      done = 1'b0;
      for (int i = 0; i < max && !done; i++) begin
         if (sb.size() == 0 && !busy) done = 1'b1;
         else tick();
      end
      if (!done) fail_now("drain_timeout");
   endtask

   initial begin
      rst = 1'b1;
      in_valid = 1'b0;
      inp_a = '0;
      inp_b = '0;
      out_ready = 1'b1;
      #12;
      check("reset_out", out, 0);
      check("reset_out_valid", out_valid, 0);
      check("reset_busy", busy, 0);
      check("reset_in_ready", in_ready, 0);
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check("in_ready_after_reset", in_ready, 1);
      tick();

      send(11'h400, 11'h400, 1'b0);
      wait_idle(100);
      send(11'h600, 11'h600, 1'b0);
      wait_idle(100);
      send(11'h7FF, 11'h7FF, 1'b0);
      wait_idle(100);

      // Backpressure: hold the result for 10 cycles, then release.
      out_ready = 1'b0;
      send(11'h600, 11'h600, 1'b0);
      for (int i = 0; i < 100 && !out_valid; i++) tick();
      if (!out_valid) fail_now("out_valid_timeout");
      repeat (10) tick();
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      check("idle_busy_after_hs", busy, 0);
      check("idle_in_ready_after_hs", in_ready, 1);

      // Back-to-back through the chained DONE->CALC path.
      send(11'h400, 11'h7FF, 1'b1);
      send(11'h555, 11'h2AA, 1'b1);
      send(11'h7FF, 11'h401, 1'b0);
      wait_idle(100);

      // Reset mid-CALC discards the operation.
      send(11'h7FF, 11'h7FF, 1'b0);
      repeat (2) tick();
      rst = 1'b1;
      #1;
      check("midcalc_rst_out", out, 0);
      check("midcalc_rst_out_valid", out_valid, 0);
      check("midcalc_rst_busy", busy, 0);
      check("midcalc_rst_in_ready", in_ready, 0);
      sb.delete();
      repeat (2) tick();
      rst = 1'b0;
      repeat (12) tick();
      check("no_response_after_rst", out_valid, 0);
      send(11'h400, 11'h400, 1'b0);
      wait_idle(100);

      // Random sweep with random output backpressure and random chaining.
      rand_rdy = 1'b1;
      for (int i = 0; i < 2000; i++) begin
         logic [W-1:0] a, b;
         bit keep;
         a = W'($urandom);
         b = W'($urandom);
         case ($urandom_range(0, 15))
            0: a = '0;
            1: b = '0;
            2: a = '1;
            3: b = '1;
            default: ;
         endcase
         keep = (i != 1999) && ($urandom_range(0, 1) == 1);
         send(a, b, keep);
      end
      rand_rdy = 1'b0;
      out_ready = 1'b1;
      wait_idle(200);
      repeat (3) tick();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
